// File: rtl/regfile_pair_reader_pkg.sv
// Shared types and widths for the register-file pair reader.
package regfile_pair_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    // One bit wider than an address so the cursor can step past register 31.
    localparam int CURSOR_W   = 6;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPTURE,
        HOLD,
        FINISH
    } state_t;

endpackage

// File: rtl/regfile_pair_reader_if.sv
// Beat stream from the pair reader to its consumer (valid/ready handshake).
interface regfile_pair_reader_if;
    import regfile_pair_reader_pkg::*;

    logic                  OutValid;
    logic                  OutReady;
    logic [REG_ADDR_W-1:0] OutReg1;
    logic [REG_ADDR_W-1:0] OutReg2;
    logic [REG_DATA_W-1:0] OutData1;
    logic [REG_DATA_W-1:0] OutData2;
    logic                  OutSecondValid;

    modport master (
        output OutValid, OutReg1, OutReg2, OutData1, OutData2, OutSecondValid,
        input  OutReady
    );

    modport slave (
        input  OutValid, OutReg1, OutReg2, OutData1, OutData2, OutSecondValid,
        output OutReady
    );

endinterface

// File: rtl/regfile_pair_reader_out.sv
// Load-enabled beat register: captures one address/data pair and holds it
// until the consumer accepts it.
module pair_out_reg
    import regfile_pair_reader_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  load,
    input  logic [REG_ADDR_W-1:0] reg1,
    input  logic [REG_ADDR_W-1:0] reg2,
    input  logic [REG_DATA_W-1:0] data1,
    input  logic [REG_DATA_W-1:0] data2,
    input  logic                  secondValid,
    regfile_pair_reader_if.master beat
);

    // Beat capture on load; OutValid clears on handshake, data stays frozen.
    always_ff @(posedge Clk) begin
        // NOTE: the data fields are reset too, because consumers may look at
        // them before the first beat and expect zeros rather than X.
        if (Reset) begin
            beat.OutValid       <= 1'b0;
            beat.OutReg1        <= '0;
            beat.OutReg2        <= '0;
            beat.OutData1       <= '0;
            beat.OutData2       <= '0;
            beat.OutSecondValid <= 1'b0;
        end else if (load) begin
            beat.OutValid       <= 1'b1;
            beat.OutReg1        <= reg1;
            beat.OutReg2        <= reg2;
            beat.OutData1       <= data1;
            beat.OutData2       <= data2;
            beat.OutSecondValid <= secondValid;
        end else if (beat.OutValid && beat.OutReady) begin
            beat.OutValid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_pair_reader.sv
// Sweeps an inclusive register range two registers at a time and streams
// each captured pair out as one beat.
module regfile_pair_reader
    import regfile_pair_reader_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [REG_ADDR_W-1:0] FirstReg,
    input  logic [REG_ADDR_W-1:0] LastReg,
    output logic [REG_ADDR_W-1:0] ReadRegister1,
    output logic [REG_ADDR_W-1:0] ReadRegister2,
    input  logic [REG_DATA_W-1:0] ReadData1,
    input  logic [REG_DATA_W-1:0] ReadData2,
    regfile_pair_reader_if.master outBus,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    state_t              state;
    state_t              nextState;
    logic [CURSOR_W-1:0] cursor;
    logic [CURSOR_W-1:0] lastReg;
    logic                errFlag;
    logic                loadBeat;
    logic                handshake;
    logic                secondInRange;
    logic                sweepEnds;

    assign handshake     = outBus.OutValid && outBus.OutReady;
    assign secondInRange = (cursor + CURSOR_W'(1)) <= lastReg;
    assign sweepEnds     = (cursor + CURSOR_W'(2)) > lastReg;

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (Start) nextState = (FirstReg <= LastReg) ? ADDR : FINISH;
            ADDR:    nextState = CAPTURE;
            CAPTURE: nextState = HOLD;
            HOLD:    if (handshake) nextState = sweepEnds ? FINISH : ADDR;
            FINISH:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Range latch on accepted Start and cursor advance on each handshake.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cursor  <= '0;
            lastReg <= '0;
            errFlag <= 1'b0;
        end else if (state == IDLE && Start) begin
            cursor  <= {1'b0, FirstReg};
            lastReg <= {1'b0, LastReg};
            errFlag <= FirstReg > LastReg;
        end else if (state == HOLD && handshake) begin
            cursor  <= cursor + CURSOR_W'(2);
        end
    end

    // Output decode: read addresses, status flags and the beat load strobe.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        Busy          = 1'b1;
        Done          = 1'b0;
        Error         = 1'b0;
        loadBeat      = 1'b0;
        unique case (state)
            IDLE: Busy = 1'b0;
            ADDR, CAPTURE, HOLD: begin
                ReadRegister1 = cursor[REG_ADDR_W-1:0];
                ReadRegister2 = secondInRange ? cursor[REG_ADDR_W-1:0] + REG_ADDR_W'(1)
                                              : cursor[REG_ADDR_W-1:0];
                loadBeat      = (state == CAPTURE);
            end
            FINISH: begin
                Done  = 1'b1;
                Error = errFlag;
            end
            default: Busy = 1'b0;
        endcase
    end

    pair_out_reg outReg (
        .Clk         (Clk),
        .Reset       (Reset),
        .load        (loadBeat),
        .reg1        (ReadRegister1),
        .reg2        (ReadRegister2),
        .data1       (ReadData1),
        .data2       (ReadData2),
        .secondValid (secondInRange),
        .beat        (outBus)
    );

endmodule
